// File: rtl/ltl_report_collector.sv
// ltl_report_collector: consumer end of one automata monitor cluster.
// Samples the cluster's report vector and tags every non-zero vector with the
// index of the symbol that produced it. The tagged records are queued in a
// small FIFO and handed to the host side over a valid/ready port.
// Optional feature (macro LTL_REPORT_DEDUP_EN): a contiguous run of identical
// report vectors is collapsed into one record at the first index of the run.
module ltl_report_collector #(
  parameter int N_REPORTS = 4,
  parameter int CNT_W     = 16,
  parameter int DEPTH     = 8,
  parameter int DROP_W    = 8,
  localparam int LW       = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 run,
  input  logic [N_REPORTS-1:0] reports,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     out_index,
  output logic [N_REPORTS-1:0] out_reports,
  output logic                 overflow,
  output logic [DROP_W-1:0]    drop_count,
  output logic [LW-1:0]        fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  // Output handshake: a record transfers on every edge where out_valid and
  // out_ready are both high. out_valid never drops and the head record never
  // changes until that transfer happens; only clear/reset can withdraw it.

  logic [CNT_W-1:0]     idx;
  logic [CNT_W-1:0]     idx_q;
  logic                 run_q;
  logic [CNT_W-1:0]     idx_mem [DEPTH];
  logic [N_REPORTS-1:0] rep_mem [DEPTH];
  logic [LW-1:0]        wr_ptr;
  logic [LW-1:0]        rd_ptr;
  logic [LW-1:0]        level;
  logic                 full;
  logic                 pop;
  logic                 cand;
  logic                 suppress;
  logic                 push;
  logic                 drop;

  assign level       = wr_ptr - rd_ptr;
  assign full        = (level == FULL_LEVEL);
  assign out_valid   = (level != '0);
  assign pop         = out_valid && out_ready;
  // reports belong to the symbol presented one cycle earlier
  assign cand        = run_q && (reports != '0);
  assign push        = cand && !suppress && (!full || pop);
  assign drop        = cand && !suppress && full && !pop;
  assign fifo_level  = level;
  // storage is not reset, so the head is forced to zero while the FIFO is empty
  assign out_index   = out_valid ? idx_mem[rd_ptr[AW-1:0]] : '0;
  assign out_reports = out_valid ? rep_mem[rd_ptr[AW-1:0]] : '0;

  // Symbol index counter delayed by one cycle to line up with the report vector.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx   <= '0;
      idx_q <= '0;
      run_q <= 1'b0;
    end else if (clear) begin
      idx   <= '0;
      idx_q <= '0;
      run_q <= 1'b0;
    end else begin
      run_q <= run;
      idx_q <= idx;
      if (run) idx <= idx + CNT_W'(1);
    end
  end

  // Record storage; a push into a full FIFO overwrites the slot being popped.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      idx_mem[wr_ptr[AW-1:0]] <= idx_q;
      rep_mem[wr_ptr[AW-1:0]] <= reports;
    end
  end

  // FIFO pointers; the extra top bit separates full from empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LW'(1);
      if (pop)  rd_ptr <= rd_ptr + LW'(1);
    end
  end

  // Sticky overflow flag and saturating count of dropped records.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != {DROP_W{1'b1}}) drop_count <= drop_count + DROP_W'(1);
    end
  end

`ifdef LTL_REPORT_DEDUP_EN
  logic                 hist_valid;
  logic [CNT_W-1:0]     hist_idx;
  logic [N_REPORTS-1:0] hist_rep;

  assign suppress = cand && hist_valid && (reports == hist_rep) &&
                    (idx_q == CNT_W'(hist_idx + CNT_W'(1)));

  // History of the last pushed record; a suppressed repeat advances its index
  // so the next identical vector is still seen as contiguous.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_valid <= 1'b0;
      hist_idx   <= '0;
      hist_rep   <= '0;
    end else if (clear) begin
      hist_valid <= 1'b0;
      hist_idx   <= '0;
      hist_rep   <= '0;
    end else if (suppress) begin
      hist_idx <= idx_q;
    end else if (push) begin
      hist_valid <= 1'b1;
      hist_idx   <= idx_q;
      hist_rep   <= reports;
    end
  end
`else
  assign suppress = 1'b0;
`endif

endmodule

// File: tb/tb_ltl_report_collector.sv
// Bench for ltl_report_collector: directed scenarios followed by random traffic,
// checked every cycle against a queue-based reference model. Two instances share
// the stimulus: the default 16-bit index and a 4-bit index to exercise wrap.
module tb_ltl_report_collector;

  localparam int N     = 4;
  localparam int CW    = 16;
  localparam int CW4   = 4;
  localparam int DEPTH = 8;
  localparam int DW    = 8;
  localparam int LW    = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear = 1'b0;
  logic          run = 1'b0;
  logic [N-1:0]  reports = '0;
  logic          out_ready = 1'b0;

  logic          out_valid_a, overflow_a;
  logic [CW-1:0] out_index_a;
  logic [N-1:0]  out_reports_a;
  logic [DW-1:0] drop_count_a;
  logic [LW-1:0] fifo_level_a;

  logic           out_valid_b, overflow_b;
  logic [CW4-1:0] out_index_b;
  logic [N-1:0]   out_reports_b;
  logic [DW-1:0]  drop_count_b;
  logic [LW-1:0]  fifo_level_b;

  ltl_report_collector dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .run(run), .reports(reports),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_index(out_index_a),
    .out_reports(out_reports_a), .overflow(overflow_a), .drop_count(drop_count_a),
    .fifo_level(fifo_level_a)
  );

  ltl_report_collector #(.CNT_W(CW4)) dut4 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .run(run), .reports(reports),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_index(out_index_b),
    .out_reports(out_reports_b), .overflow(overflow_b), .drop_count(drop_count_b),
    .fifo_level(fifo_level_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state: records are {index[15:0], reports[3:0]}
  int vectors = 0;
  int miscompares = 0;
  logic [CW+N-1:0] exp_q0[$];
  logic [CW+N-1:0] exp_q1[$];
  bit   pend_v;
  int   pend_idx;
  int   sym;
  bit   ovf [2];
  int   drops [2];
  bit   fresh [2];
  bit   hv [2];
  int   hidx [2];
  logic [N-1:0] hrep [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    pend_v = 1'b0;
    pend_idx = 0;
    sym = 0;
    for (int l = 0; l < 2; l++) begin
      ovf[l] = 1'b0;
      drops[l] = 0;
      fresh[l] = 1'b1;
      hv[l] = 1'b0;
      hidx[l] = 0;
      hrep[l] = '0;
    end
  endtask

  // One lane of the model: what the queue does on one edge given the inputs.
  task automatic lane_edge(input int l, input logic [N-1:0] rep, input bit rdy);
    int mask, sz, pidx;
    bit pop, cand, sup;
    logic [CW+N-1:0] rec;
    mask = (l == 0) ? 32'hFFFF : 32'hF;
    sz   = (l == 0) ? exp_q0.size() : exp_q1.size();
    pop  = (sz != 0) && rdy;
    cand = pend_v && (rep != '0);
    sup  = 1'b0;
    pidx = pend_idx & mask;
`ifdef LTL_REPORT_DEDUP_EN
    if (cand && hv[l] && rep == hrep[l] && pidx == ((hidx[l] + 1) & mask)) sup = 1'b1;
`endif
    if (pop) begin
      if (l == 0) exp_q0.delete(0); else exp_q1.delete(0);
    end
    if (sup) begin
      hidx[l] = pidx;
    end else if (cand) begin
      if (sz < DEPTH || pop) begin
        rec = {16'(pidx), rep};
        if (l == 0) exp_q0.push_back(rec); else exp_q1.push_back(rec);
        hv[l] = 1'b1;
        hidx[l] = pidx;
        hrep[l] = rep;
        fresh[l] = 1'b0;
      end else begin
        ovf[l] = 1'b1;
        if (drops[l] < 255) drops[l]++;
      end
    end
  endtask

  task automatic model_edge(input bit c, input bit r, input logic [N-1:0] rep, input bit rdy);
    if (c) begin
      model_reset();
    end else begin
      for (int l = 0; l < 2; l++) lane_edge(l, rep, rdy);
      pend_v = r;
      pend_idx = sym;
      if (r) sym++;
    end
  endtask

  task automatic check_lane(input int l, input logic v, input logic [LW-1:0] lvl,
                            input logic [31:0] oi, input logic [N-1:0] orp,
                            input logic ov, input logic [DW-1:0] dc);
    int sz;
    logic [CW+N-1:0] head;
    sz = (l == 0) ? exp_q0.size() : exp_q1.size();
    head = '0;
    if (sz != 0) head = (l == 0) ? exp_q0[0] : exp_q1[0];
    chk($sformatf("out_valid[%0d]", l), 32'(v), 32'(sz != 0));
    chk($sformatf("fifo_level[%0d]", l), 32'(lvl), 32'(sz));
    chk($sformatf("overflow[%0d]", l), 32'(ov), 32'(ovf[l]));
    chk($sformatf("drop_count[%0d]", l), 32'(dc), 32'(drops[l]));
    if (sz != 0 || fresh[l]) begin
      chk($sformatf("out_index[%0d]", l), oi, 32'(head[CW+N-1:N]));
      chk($sformatf("out_reports[%0d]", l), 32'(orp), 32'(head[N-1:0]));
    end
  endtask

  task automatic check_all();
    check_lane(0, out_valid_a, fifo_level_a, 32'(out_index_a), out_reports_a, overflow_a, drop_count_a);
    check_lane(1, out_valid_b, fifo_level_b, 32'(out_index_b), out_reports_b, overflow_b, drop_count_b);
  endtask

  // driver: one clock cycle of inputs, model update at the edge, check after it
  task automatic step(input bit c, input bit r, input logic [N-1:0] rep, input bit rdy);
    @(negedge clk);
    clear = c;
    run = r;
    reports = rep;
    out_ready = rdy;
    @(posedge clk);
    model_edge(c, r, rep, rdy);
    #1 check_all();
  endtask

  initial begin
    logic [N-1:0] rr;
    bit rdy_bias;

    // reset state held before the first edge after release
    model_reset();
    #12 check_all();
    chk("reset_valid", 32'(out_valid_a), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // single report on the third symbol, two-cycle latency
    step(0, 1, 4'b0000, 0);
    step(0, 1, 4'b0000, 0);
    step(0, 1, 4'b0000, 0);
    chk("t1_not_yet", 32'(out_valid_a), 32'd0);
    step(0, 1, 4'b0010, 0);
    chk("t1_valid", 32'(out_valid_a), 32'd1);
    chk("t1_index", 32'(out_index_a), 32'd2);
    chk("t1_reports", 32'(out_reports_a), 32'h2);
    step(0, 1, 4'b0000, 0);
    step(0, 0, 4'b0000, 0);
    step(0, 0, 4'b0000, 1);
    chk("t1_drained", 32'(out_valid_a), 32'd0);

    // ten qualifying symbols into a stalled FIFO, then drain
    step(1, 0, 4'b0000, 0);
    step(0, 1, 4'b0000, 0);
    for (int k = 0; k < 9; k++) step(0, 1, 4'b0001, 0);
    step(0, 0, 4'b0001, 0);
`ifndef LTL_REPORT_DEDUP_EN
    chk("t2_level", 32'(fifo_level_a), 32'd8);
    chk("t2_overflow", 32'(overflow_a), 32'd1);
    chk("t2_drops", 32'(drop_count_a), 32'd2);
`endif

    // full FIFO: push and pop in the same cycle, no drop
    step(0, 1, 4'b0000, 0);
    step(0, 0, 4'b0100, 1);
`ifndef LTL_REPORT_DEDUP_EN
    chk("t3_level", 32'(fifo_level_a), 32'd8);
    chk("t3_drops", 32'(drop_count_a), 32'd2);
`endif
    for (int k = 0; k < 10; k++) step(0, 0, 4'b0000, 1);
    chk("t3_empty", 32'(out_valid_a), 32'd0);

    // index wrap on the 4-bit instance: symbols 15 and 16 report
    step(1, 0, 4'b0000, 0);
    for (int k = 0; k < 17; k++) step(0, 1, (k == 16) ? 4'b1001 : 4'b0000, 0);
    step(0, 0, 4'b0011, 0);
    chk("t4_idx15", 32'(out_index_b), 32'd15);
    step(0, 0, 4'b0000, 1);
    chk("t4_idx0", 32'(out_index_b), 32'd0);
    chk("t4_idx16", 32'(out_index_a), 32'd16);
    step(0, 0, 4'b0000, 1);

    // clear with three records queued and a report in flight
    step(1, 0, 4'b0000, 0);
    step(0, 1, 4'b0000, 0);
    step(0, 1, 4'b0001, 0);
    step(0, 1, 4'b0010, 0);
    step(0, 1, 4'b0011, 0);
    step(1, 0, 4'b1111, 0);
    chk("t5_level", 32'(fifo_level_a), 32'd0);
    chk("t5_valid", 32'(out_valid_a), 32'd0);
    step(0, 1, 4'b1111, 0);
    step(0, 0, 4'b0101, 0);
    chk("t5_index", 32'(out_index_a), 32'd0);

    // repeated vector on symbols 4..6, different vector on 7
    step(1, 0, 4'b0000, 0);
    for (int k = 0; k < 9; k++) begin
      rr = 4'b0000;
      if (k >= 5 && k <= 7) rr = 4'b1000;
      if (k == 8) rr = 4'b0100;
      step(0, (k < 8), rr, 0);
    end
`ifdef LTL_REPORT_DEDUP_EN
    chk("t6_level", 32'(fifo_level_a), 32'd2);
`else
    chk("t6_level", 32'(fifo_level_a), 32'd4);
`endif
    for (int k = 0; k < 5; k++) step(0, 0, 4'b0000, 1);

    // random traffic with a mid-run asynchronous reset
    rdy_bias = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (n % 150 == 0) rdy_bias = ($urandom_range(0, 1) == 1);
      if (n == 1500) begin
        @(negedge clk);
        run = 1'b0;
        clear = 1'b0;
        out_ready = 1'b0;
        reset_n = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        reset_n = 1'b1;
      end
      case ($urandom_range(0, 3))
        0: rr = 4'b0000;
        1: rr = 4'b0001;
        2: rr = 4'b1000;
        default: rr = 4'($urandom_range(0, 15));
      endcase
      step(($urandom_range(0, 249) == 0), ($urandom_range(0, 3) != 0), rr,
           rdy_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
